// File: rtl/kick_cmd.sv
// Kicker initiator: turns kick requests into a shoot/pulse-width command, waits for Done,
// then holds off for a recharge cooldown while gating the capacitor charger.
module kick_cmd #(
  parameter int unsigned ARM_TIMEOUT = 50000000,
  parameter int unsigned COOLDOWN    = 25000000,
  parameter int unsigned PW_STEP     = 1000,
  parameter int unsigned PW_MAX      = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [6:0]  power,
  input  logic        cancel,
  input  logic        done_in,
  output logic        shoot,
  output logic [31:0] wrdata,
  output logic        charge_en,
  output logic        busy,
  output logic        fired,
  output logic        timeout,
  output logic        rejected,
  output logic [15:0] kick_count
);

  localparam int unsigned TW = 32;
  localparam int unsigned KW = 16;
  localparam logic [TW-1:0] ARM_LAST  = TW'(ARM_TIMEOUT - 1);
  localparam logic [TW-1:0] COOL_LAST = TW'(COOLDOWN - 1);

  typedef enum logic [1:0] {IDLE, ARM, HOLD, COOL} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            done_q;
  logic [31:0]     wrdata_q, wrdata_d;
  logic [KW-1:0]   kick_q, kick_d;
  logic            shoot_q, shoot_d;
  logic            charge_q, charge_d;
  logic            busy_q, busy_d;
  logic            fired_q, fired_d;
  logic            timeout_q, timeout_d;
  logic            rejected_q, rejected_d;

  logic [31:0]     prod_c;
  logic [31:0]     width_c;
  logic            done_rise_c;
  logic            valid_req_c;

  // Strength to pulse width, clamped so a bad power value cannot over-discharge.
  assign prod_c      = 32'(power) * 32'(PW_STEP);
  assign width_c     = (prod_c > 32'(PW_MAX)) ? 32'(PW_MAX) : prod_c;
  assign done_rise_c = done_in & ~done_q;
  assign valid_req_c = req & (power != 7'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      done_q     <= 1'b0;
      wrdata_q   <= '0;
      kick_q     <= '0;
      shoot_q    <= 1'b0;
      charge_q   <= 1'b1;
      busy_q     <= 1'b0;
      fired_q    <= 1'b0;
      timeout_q  <= 1'b0;
      rejected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      done_q     <= done_in;
      wrdata_q   <= wrdata_d;
      kick_q     <= kick_d;
      shoot_q    <= shoot_d;
      charge_q   <= charge_d;
      busy_q     <= busy_d;
      fired_q    <= fired_d;
      timeout_q  <= timeout_d;
      rejected_q <= rejected_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    wrdata_d   = wrdata_q;
    kick_d     = kick_q;
    fired_d    = 1'b0;
    timeout_d  = 1'b0;
    rejected_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_req_c) begin
          wrdata_d = width_c;
          timer_d  = '0;
          state_d  = ARM;
        end else if (req) begin
          rejected_d = 1'b1;
        end
      end
      ARM: begin
        timer_d = timer_q + TW'(1);
        // Only a fresh Done edge acknowledges; a level left high from before is ignored.
        if (done_rise_c) begin
          state_d = HOLD;
          fired_d = 1'b1;
          kick_d  = kick_q + KW'(1);
        end else if (cancel) begin
          state_d = IDLE;
        end else if (timer_q == ARM_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else if (valid_req_c) begin
          wrdata_d = width_c;
          timer_d  = '0;
        end else if (req) begin
          rejected_d = 1'b1;
        end
      end
      HOLD: begin
        if (!done_in) begin
          timer_d = '0;
          state_d = COOL;
        end
        rejected_d = req;
      end
      COOL: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == COOL_LAST) begin
          state_d = IDLE;
        end
        rejected_d = req;
      end
      default: state_d = IDLE;
    endcase

    shoot_d  = (state_d == ARM);
    charge_d = !((state_d == ARM) || (state_d == HOLD));
    busy_d   = (state_d != IDLE);
  end

  assign shoot      = shoot_q;
  assign wrdata     = wrdata_q;
  assign charge_en  = charge_q;
  assign busy       = busy_q;
  assign fired      = fired_q;
  assign timeout    = timeout_q;
  assign rejected   = rejected_q;
  assign kick_count = kick_q;

endmodule

// File: tb/tb_kick_cmd.sv
// Directed bench for kick_cmd: level checks inline, pulse events matched against a queue
// of expected (kind, edge, kick_count) entries by a negedge monitor.
module tb_kick_cmd;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [6:0]  power;
  logic        cancel;
  logic        done_in;
  logic        shoot;
  logic [31:0] wrdata;
  logic        charge_en;
  logic        busy;
  logic        fired;
  logic        timeout;
  logic        rejected;
  logic [15:0] kick_count;

  kick_cmd #(
    .ARM_TIMEOUT(100),
    .COOLDOWN   (50),
    .PW_STEP    (10),
    .PW_MAX     (1000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .power     (power),
    .cancel    (cancel),
    .done_in   (done_in),
    .shoot     (shoot),
    .wrdata    (wrdata),
    .charge_en (charge_en),
    .busy      (busy),
    .fired     (fired),
    .timeout   (timeout),
    .rejected  (rejected),
    .kick_count(kick_count)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] K_FIRED = 3'b100;
  localparam logic [2:0] K_TOUT  = 3'b010;
  localparam logic [2:0] K_REJ   = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    int unsigned cyc;
    logic [15:0] kc;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic [2:0] kind, input int unsigned at, input logic [15:0] kc);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.kc   = kc;
    exp_q.push_back(e);
  endtask

  // Every pulse must match the oldest outstanding expectation exactly.
  always @(negedge clk) begin
    if (fired | timeout | rejected) begin
      chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        ev_t e;
        e = exp_q.pop_front();
        chk("pulse_kind", 32'({fired, timeout, rejected}), 32'(e.kind));
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        chk("pulse_kick_count", 32'(kick_count), 32'(e.kc));
      end
    end
  end

  int unsigned a;
  int unsigned b;

  initial begin
    reset = 1'b0; req = 1'b0; power = '0; cancel = 1'b0; done_in = 1'b0;
    tick(3);
    chk("rst_shoot", 32'(shoot), 32'd0);
    chk("rst_wrdata", wrdata, 32'd0);
    chk("rst_charge_en", 32'(charge_en), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_kick_count", 32'(kick_count), 32'd0);
    chk("rst_pulses", 32'({fired, timeout, rejected}), 32'd0);
    reset = 1'b1;
    tick();

    // Normal kick
    power = 7'd37; req = 1'b1;
    tick(); req = 1'b0;
    chk("norm_shoot", 32'(shoot), 32'd1);
    chk("norm_wrdata", wrdata, 32'd370);
    chk("norm_busy", 32'(busy), 32'd1);
    chk("norm_charge_off", 32'(charge_en), 32'd0);
    tick(19);
    done_in = 1'b1;
    expect_ev(K_FIRED, cyc + 1, 16'd1);
    tick();
    chk("norm_shoot_drop", 32'(shoot), 32'd0);
    chk("norm_kick_count", 32'(kick_count), 32'd1);
    tick(15);
    chk("norm_hold_charge", 32'(charge_en), 32'd0);
    done_in = 1'b0;
    tick();
    chk("norm_cool_charge", 32'(charge_en), 32'd1);
    tick(49);
    chk("norm_cool_busy", 32'(busy), 32'd1);
    tick();
    chk("norm_idle_busy", 32'(busy), 32'd0);

    // Zero power rejected, then clamp
    power = 7'd0; req = 1'b1;
    expect_ev(K_REJ, cyc + 1, 16'd1);
    tick(); req = 1'b0;
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_wrdata", wrdata, 32'd370);
    power = 7'd127; req = 1'b1;
    tick(); req = 1'b0;
    chk("clamp_wrdata", wrdata, 32'd1000);
    chk("clamp_shoot", 32'(shoot), 32'd1);
    cancel = 1'b1;
    tick(); cancel = 1'b0;
    chk("clamp_cancel_busy", 32'(busy), 32'd0);

    // Timeout
    power = 7'd5; req = 1'b1;
    tick(); req = 1'b0;
    a = cyc;
    expect_ev(K_TOUT, a + 100, 16'd1);
    tick(99);
    chk("tout_still_armed", 32'(shoot), 32'd1);
    tick();
    chk("tout_shoot", 32'(shoot), 32'd0);
    chk("tout_charge_en", 32'(charge_en), 32'd1);
    chk("tout_busy", 32'(busy), 32'd0);
    chk("tout_wrdata", wrdata, 32'd50);
    chk("tout_kick_count", 32'(kick_count), 32'd1);

    // Stale Done, cancel, immediate re-request
    done_in = 1'b1;
    tick();
    power = 7'd3; req = 1'b1;
    tick(); req = 1'b0;
    chk("stale_shoot", 32'(shoot), 32'd1);
    tick(9);
    chk("stale_no_fire", 32'(shoot), 32'd1);
    cancel = 1'b1;
    tick(); cancel = 1'b0;
    chk("cancel_busy", 32'(busy), 32'd0);
    chk("cancel_shoot", 32'(shoot), 32'd0);
    power = 7'd4; req = 1'b1;
    tick(); req = 1'b0;
    chk("rereq_shoot", 32'(shoot), 32'd1);
    chk("rereq_wrdata", wrdata, 32'd40);
    done_in = 1'b0;
    tick();
    done_in = 1'b1;
    expect_ev(K_FIRED, cyc + 1, 16'd2);
    tick();
    chk("rereq_kick_count", 32'(kick_count), 32'd2);
    done_in = 1'b0;
    tick();

    // Request during cooldown is rejected and leaves state alone
    power = 7'd9; req = 1'b1;
    expect_ev(K_REJ, cyc + 1, 16'd2);
    tick(); req = 1'b0;
    chk("cool_rej_busy", 32'(busy), 32'd1);
    chk("cool_rej_wrdata", wrdata, 32'd40);
    chk("cool_rej_shoot", 32'(shoot), 32'd0);
    tick(48);
    chk("cool_end_busy", 32'(busy), 32'd1);
    tick();
    chk("cool_idle_busy", 32'(busy), 32'd0);

    // Re-arm restarts the arm timer
    power = 7'd10; req = 1'b1;
    tick(); req = 1'b0;
    chk("rearm1_wrdata", wrdata, 32'd100);
    tick(89);
    power = 7'd20; req = 1'b1;
    tick(); req = 1'b0;
    b = cyc;
    expect_ev(K_TOUT, b + 100, 16'd2);
    chk("rearm2_wrdata", wrdata, 32'd200);
    tick(10);
    chk("rearm_no_early_tout", 32'(busy), 32'd1);
    tick(89);
    chk("rearm_last_cycle", 32'(shoot), 32'd1);
    tick();
    chk("rearm_tout_busy", 32'(busy), 32'd0);

    // Reset mid-ARM
    power = 7'd50; req = 1'b1;
    tick(); req = 1'b0;
    chk("rstarm_wrdata", wrdata, 32'd500);
    tick(5);
    reset = 1'b0;
    tick();
    chk("rstarm_shoot", 32'(shoot), 32'd0);
    chk("rstarm_wrdata0", wrdata, 32'd0);
    chk("rstarm_busy", 32'(busy), 32'd0);
    chk("rstarm_charge_en", 32'(charge_en), 32'd1);
    chk("rstarm_kick_count", 32'(kick_count), 32'd0);
    reset = 1'b1;
    tick();

    // kick_count wrap
    force dut.kick_q = 16'hFFFF;
    tick();
    release dut.kick_q;
    tick();
    chk("wrap_preload", 32'(kick_count), 32'hFFFF);
    power = 7'd1; req = 1'b1;
    tick(); req = 1'b0;
    done_in = 1'b1;
    expect_ev(K_FIRED, cyc + 1, 16'd0);
    tick();
    chk("wrap_kick_count", 32'(kick_count), 32'd0);
    done_in = 1'b0;
    tick(55);
    chk("final_busy", 32'(busy), 32'd0);
    chk("pending_events", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kick_cmd.md
# kick_cmd

Initiator-side controller for the kicker discharge block on the core board. It accepts kick requests from the main controller: a strength value plus a one-cycle request strobe. It converts the strength to a discharge pulse width and presents `shoot`/`wrdata` to the kicker. It then waits for the kicker's `Done` acknowledgement, reports the outcome, and enforces a recharge cooldown before the next kick. It also owns the capacitor charger enable, inhibiting charging while the kicker is armed or discharging.

## Interface
Parameters:
- `ARM_TIMEOUT`, 50000000: cycles the kicker stays armed without a `Done` before the request is abandoned.
- `COOLDOWN`, 25000000: cycles after a kick before a new request is accepted.
- `PW_STEP`, 1000: pulse-width cycles per unit of `power`.
- `PW_MAX`, 100000: upper clamp on pulse width, in cycles.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low; clock clk.
- `req`  in  1  kick request strobe, one cycle.
- `power`  in  7  kick strength; sampled with `req`.
- `cancel`  in  1  abort an armed kick.
- `done_in`  in  1  kicker `Done` level.
- `shoot`  out  1  arm command to kicker.
- `wrdata`  out  32  pulse width to kicker.
- `charge_en`  out  1  capacitor charger enable.
- `busy`  out  1  high whenever state is not IDLE.
- `fired`  out  1  one-cycle pulse: kick completed.
- `timeout`  out  1  one-cycle pulse: armed kick abandoned.
- `rejected`  out  1  one-cycle pulse: request ignored.
- `kick_count`  out  16  completed kicks; wraps 0xFFFF→0.

## Operation
- All outputs are registered.
- Reset values:
  - `shoot`=0, `wrdata`=0, `charge_en`=1, `busy`=0.
  - `fired`, `timeout`, `rejected` all 0.
  - `kick_count`=0.
  - state=IDLE, timer=0, `done_d`=0.
- `done_d` is a one-cycle delayed copy of `done_in`. Rising edge = `done_in`&!`done_d`.
- Width = `power`×`PW_STEP`, computed in 32 bits, clamped to `PW_MAX`.
- IDLE:
  - `shoot`=0, `charge_en`=1.
  - `req` with `power`≠0: load `wrdata`=width, timer=0, go to ARM.
  - `req` with `power`=0: pulse `rejected`, stay in IDLE.
- ARM:
  - `shoot`=1, `charge_en`=0. Timer increments every cycle.
  - Priority, highest first:
    1. Rising edge of `done_in`: go to HOLD, pulse `fired`, increment `kick_count`.
    2. `cancel`: go to IDLE with no pulse.
    3. timer = `ARM_TIMEOUT`−1: go to IDLE, pulse `timeout`.
    4. `req` with `power`≠0: reload `wrdata`, timer=0, stay in ARM.
    5. `req` with `power`=0: pulse `rejected`.
  - A `done_in` already high on ARM entry is not an acknowledgement; only a rising edge counts.
- HOLD:
  - `shoot`=0, `charge_en`=0.
  - `done_in`=0: timer=0, go to COOL.
  - `req`: pulse `rejected`.
- COOL:
  - `shoot`=0, `charge_en`=1.
  - timer = `COOLDOWN`−1: go to IDLE.
  - `req`: pulse `rejected`.
- `wrdata` holds its last loaded value until the next accepted request.
- `cancel` has no effect outside ARM.

## Timing
- `req` sampled at edge N is accepted: `shoot`=1, `wrdata` valid and `busy`=1 from edge N; all three are visible in cycle N+1.
- `done_in` rising edge sampled at edge M:
  - `shoot`=0 and `fired`=1 from edge M.
  - `fired` is high for exactly one cycle.
  - `kick_count` is updated at the same edge.
- ARM lasts at most `ARM_TIMEOUT` cycles; `timeout` is asserted in the same cycle as the return to IDLE.
- `done_in` sampled low in HOLD at edge K: COOL starts at K. IDLE is re-entered at K+`COOLDOWN`, where the first new `req` can be accepted.
- `reset` low at any edge returns every output to its reset value at that edge, including mid-ARM. `shoot` drops immediately.
- Pulses (`fired`, `timeout`, `rejected`) are never asserted simultaneously.

## Test plan
Benches use `ARM_TIMEOUT`=100, `COOLDOWN`=50, `PW_STEP`=10, `PW_MAX`=1000.
- **Normal kick:**
  - Stimulus: `req`, `power`=37; `done_in` rises 20 cycles later and falls 16 cycles after that.
  - Response:
    - `wrdata`=370 and `shoot`=1 the cycle after `req`.
    - `fired` one cycle long; `shoot`=0 at the same edge; `kick_count`=1.
    - `charge_en`=0 until `done_in` falls.
    - `busy`=0 exactly 50 cycles after `done_in` falls.
- **Clamp and zero:**
  - `power`=127 → `wrdata`=1000.
  - `power`=0 in IDLE → `rejected` one cycle, `busy` stays 0, `wrdata` unchanged.
- **Timeout:** `req`, `power`=5, `done_in` held 0 → `timeout` pulses 100 cycles after arming, `shoot`=0, `charge_en`=1, `kick_count` unchanged.
- **Cancel and stale Done:**
  - `done_in` held 1 before `req` → no `fired` while it stays 1.
  - `cancel` at cycle 10 of ARM → IDLE, no pulses.
  - A second `req` is accepted the next cycle.
- **Re-arm and cooldown reject:**
  - `req` `power`=10, then `req` `power`=20 at ARM cycle 90 → `wrdata`=200 and no timeout until 100 cycles after the second `req`.
  - `req` during COOL → `rejected`, state unaffected.
- **Reset mid-ARM and wrap:**
  - `reset`=0 during ARM → `shoot`=0, `wrdata`=0, `busy`=0 at that edge.
  - Preload 65535 kicks → next `fired` gives `kick_count`=0.
